lane_xform_pipe: RTL and testbench

- Registered, valid/ready streaming stage that applies a per-lane nibble transform (invert / pass / rotate-left-1) to a multi-lane data word.
- Sits directly upstream of the lane-parallel configurable transform blocks in the wrapper layer.
- Provides buffering, backpressure and run-time mode selection that the purely combinational lane blocks lack.
- Per-lane reset modes are parameters, so hierarchical overrides through generate scopes keep working.

---
 rtl/lane_xform_pipe_pkg.sv | 19 +
 rtl/lane_xform_pipe_if.sv | 28 ++
 rtl/lane_xform_pipe_fn.sv | 22 ++
 rtl/lane_xform_pipe.sv | 92 +++++++++
 tb/tb_lane_xform_pipe.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lane_xform_pipe_pkg.sv
// Shared definitions for the lane transform pipe: per-lane mode encodings.
package lane_xform_pipe_pkg;

    // Lane mode encodings; 2'd3 behaves like MODE_ROT.
    localparam logic [1:0] MODE_INV  = 2'd0;
    localparam logic [1:0] MODE_PASS = 2'd1;
    localparam logic [1:0] MODE_ROT  = 2'd2;

    // Rotate a lane value left by one bit.
    function automatic logic [31:0] rotl1(input logic [31:0] x, input int w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < w; b++) begin
            r[(b + 1) % w] = x[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/lane_xform_pipe_if.sv
// Stream, config and status signals of the lane transform pipe.
// slave = the pipe itself, master = whatever drives it.
interface lane_xform_pipe_if #(
    parameter int LANES  = 2,
    parameter int LANE_W = 4,
    parameter int CNT_W  = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*LANE_W-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*LANE_W-1:0]   out_data;
    logic                      cfg_we;
    logic [2*LANES-1:0]        cfg_mode;
    logic                      cfg_err;
    logic [CNT_W-1:0]          xfer_count;

    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_mode,
        output in_ready, out_valid, out_data, cfg_err, xfer_count
    );

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_mode,
        input  in_ready, out_valid, out_data, cfg_err, xfer_count
    );
endinterface

// File: rtl/lane_xform_pipe_fn.sv
// Combinational per-lane transform: invert, pass or rotate-left-1.
module lane_xform_fn
    import lane_xform_pipe_pkg::*;
#(
    parameter int LANE_W = 4
) (
    input  logic [1:0]        mode,
    input  logic [LANE_W-1:0] din,
    output logic [LANE_W-1:0] dout
);

    // Select the transform for this lane from its 2-bit mode.
    always_comb begin
        dout = din;
        case (mode)
            MODE_INV:  dout = ~din;
            MODE_PASS: dout = din;
            default:   dout = {din[LANE_W-2:0], din[LANE_W-1]};
        endcase
    end

endmodule

// File: rtl/lane_xform_pipe.sv
// Valid/ready stage: transforms each lane at input acceptance, buffers the
// result in a 2-entry FIFO, loads lane modes at run time and counts output
// handshakes. in_ready depends only on registers, never on out_ready.
module lane_xform_pipe
    import lane_xform_pipe_pkg::*;
#(
    parameter int                           LANES    = 2,
    parameter int                           LANE_W   = 4,
    parameter logic [2*LANES-1:0]           MODE_RST = '0,
    parameter int                           CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    lane_xform_pipe_if.slave  bus
);

    localparam int W = LANES * LANE_W;

    logic [1:0]         r_cnt;
    logic [W-1:0]       r_head;
    logic [W-1:0]       r_tail;
    logic [2*LANES-1:0] r_mode;
    logic               r_err;
    logic [CNT_W-1:0]   r_xfer;

    logic [W-1:0]       w_xf;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_cfg_ok;

    assign w_in_fire  = bus.in_valid  && (r_cnt != 2'd2);
    assign w_out_fire = bus.out_ready && (r_cnt != 2'd0);
    // Mode changes only on an empty pipe with no beat entering, so every
    // buffered beat was transformed with a single, well-defined mode.
    assign w_cfg_ok   = bus.cfg_we && (r_cnt == 2'd0) && !w_in_fire;

    assign bus.in_ready   = (r_cnt != 2'd2);
    assign bus.out_valid  = (r_cnt != 2'd0);
    assign bus.out_data   = r_head;
    assign bus.cfg_err    = r_err;
    assign bus.xfer_count = r_xfer;

    for (genvar i = 0; i < LANES; i++) begin : lane
        lane_xform_fn #(.LANE_W(LANE_W)) fn (
            .mode (r_mode[2*i +: 2]),
            .din  (bus.in_data[i*LANE_W +: LANE_W]),
            .dout (w_xf[i*LANE_W +: LANE_W])
        );
    end

    // FIFO: head is the registered output word, tail is the second slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({w_in_fire, w_out_fire})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= w_xf;
                    else               r_tail <= w_xf;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                // Both fire only at count 1: new beat replaces the head.
                2'b11:   r_head <= w_xf;
                default: ;
            endcase
        end
    end

    // Mode register load and one-cycle reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_RST;
            r_err  <= 1'b0;
        end else begin
            if (w_cfg_ok) r_mode <= bus.cfg_mode;
            r_err <= bus.cfg_we && !w_cfg_ok;
        end
    end

    // Output handshake counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_xfer <= '0;
        else if (w_out_fire) r_xfer <= r_xfer + 1'b1;
    end

endmodule

// File: tb/tb_lane_xform_pipe.sv
// Self-checking bench for lane_xform_pipe (LANES=2, LANE_W=4, CNT_W=4).
module tb_lane_xform_pipe;
    import lane_xform_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lane_xform_pipe_if #(.LANES(2), .LANE_W(4), .CNT_W(4)) bus ();

    lane_xform_pipe #(
        .LANES(2), .LANE_W(4), .MODE_RST(4'b0000), .CNT_W(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] q[$];
    int         m_mode = 0;
    int         m_xfer = 0;
    logic       m_err  = 1'b0;
    int         n_out  = 0;

    // Transform from the lane rules, in plain arithmetic.
    function automatic logic [7:0] ref_xf(input int md, input int d);
        int r;
        r = 0;
        for (int l = 0; l < 2; l++) begin
            int x, m, y;
            x = (d >> (4*l)) % 16;
            m = (md >> (2*l)) % 4;
            if (m == 0)      y = 15 - x;
            else if (m == 1) y = x;
            else             y = (x * 2) % 16 + x / 8;
            r = r + (y << (4*l));
        end
        return r[7:0];
    endfunction

    // Advance the model with current inputs, then one clock.
    task automatic cycle();
        bit inf, outf, acc;
        inf  = bus.in_valid && (q.size() < 2);
        outf = bus.out_ready && (q.size() > 0);
        acc  = bus.cfg_we && (q.size() == 0) && !inf;
        if (outf) begin
            void'(q.pop_front());
            m_xfer = (m_xfer + 1) % 16;
            n_out++;
        end
        if (inf) q.push_back(ref_xf(m_mode, int'(bus.in_data)));
        if (acc) m_mode = int'(bus.cfg_mode);
        m_err = bus.cfg_we && !acc;
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_mode = 0;
        m_xfer = 0;
        m_err  = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data: got %h want 00", bus.out_data); end
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err: got %b want 0", bus.cfg_err); end
        total++; if (bus.xfer_count !== 4'd0) begin bad++; $display("FAIL rst_xfer: got %0d want 0", bus.xfer_count); end
    endtask

    task automatic test_invert();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'hCA;
        cycle();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL inv_valid: got %b want 1", bus.out_valid); end
        total++; if (bus.out_data !== 8'h35) begin bad++; $display("FAIL inv_data: got %h want 35", bus.out_data); end
        cycle();
        total++; if (bus.xfer_count !== 4'd1) begin bad++; $display("FAIL inv_xfer: got %0d want 1", bus.xfer_count); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL inv_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_cfg_pass();
        bus.cfg_we = 1'b1; bus.cfg_mode = 4'b0001;
        cycle();
        bus.cfg_we = 1'b0;
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL pass_cfg_err: got %b want 0", bus.cfg_err); end
        bus.in_valid = 1'b1; bus.in_data = 8'hCA;
        cycle();
        total++; if (bus.out_data !== 8'h3A) begin bad++; $display("FAIL pass_ca: got %h want 3a", bus.out_data); end
        bus.in_data = 8'hAF;
        cycle();
        total++; if (bus.out_data !== 8'h5F) begin bad++; $display("FAIL pass_af: got %h want 5f", bus.out_data); end
        bus.in_valid = 1'b0;
        cycle();
        total++; if (bus.xfer_count !== 4'(m_xfer)) begin bad++; $display("FAIL pass_xfer: got %0d want %0d", bus.xfer_count, m_xfer); end
    endtask

    task automatic test_cfg_rot();
        bus.cfg_we = 1'b1; bus.cfg_mode = 4'b0010;
        cycle();
        bus.cfg_we = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'hCA;
        cycle();
        bus.in_valid = 1'b0;
        total++; if (bus.out_data !== 8'h35) begin bad++; $display("FAIL rot_ca: got %h want 35", bus.out_data); end
        cycle();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h01;
        cycle();
        bus.in_data = 8'h02;
        cycle();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got %b want 0", bus.in_ready); end
        bus.in_data = 8'h03;
        cycle(); cycle();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_held_rdy: got %b want 0", bus.in_ready); end
        total++; if (bus.out_data !== 8'hF2) begin bad++; $display("FAIL bp_held_data: got %h want f2", bus.out_data); end
        bus.out_ready = 1'b1;
        cycle();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hF4) begin bad++; $display("FAIL bp_second: got %b/%h want 1/f4", bus.out_valid, bus.out_data); end
        cycle();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hF6) begin bad++; $display("FAIL bp_third: got %b/%h want 1/f6", bus.out_valid, bus.out_data); end
        cycle();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_cfg_err();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'hCA;
        cycle();
        bus.in_valid = 1'b0;
        bus.cfg_we = 1'b1; bus.cfg_mode = 4'b0101;
        cycle();
        bus.cfg_we = 1'b0;
        total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL err_pulse: got %b want 1", bus.cfg_err); end
        cycle();
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle: got %b want 0", bus.cfg_err); end
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b1; bus.in_data = 8'hCA;
        cycle();
        bus.in_valid = 1'b0;
        total++; if (bus.out_data !== 8'h35) begin bad++; $display("FAIL err_mode_kept: got %h want 35", bus.out_data); end
        cycle();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h11;
        cycle();
        bus.in_data = 8'h22;
        cycle();
        bus.in_valid = 1'b0;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_full: got %b want 0", bus.in_ready); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.xfer_count !== 4'd0) begin bad++; $display("FAIL mid_xfer: got %0d want 0", bus.xfer_count); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_discard: got %b want 0", bus.out_valid); end
    endtask

    // Stream 16 beats after reset: checks restored mode and counter wrap.
    task automatic test_wrap();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h01;
        n_out = 0;
        cycle();
        total++; if (bus.out_data !== 8'hFE) begin bad++; $display("FAIL wrap_mode_rst: got %h want fe", bus.out_data); end
        for (int k = 0; k < 15; k++) begin
            bus.in_data = 8'($urandom);
            cycle();
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== q[0]) begin bad++; $display("FAIL wrap_stream: got %b/%h want 1/%h", bus.out_valid, bus.out_data, q[0]); end
        end
        total++; if (bus.xfer_count !== 4'd15 || n_out != 15) begin bad++; $display("FAIL wrap_15: got %0d want 15", bus.xfer_count); end
        bus.in_valid = 1'b0;
        cycle();
        total++; if (bus.xfer_count !== 4'd0 || n_out != 16) begin bad++; $display("FAIL wrap_0: got %0d want 0", bus.xfer_count); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.cfg_we    = ($urandom_range(0, 9) == 0);
            bus.cfg_mode  = 4'($urandom);
            bus.in_data   = 8'($urandom);
            cycle();
            total++; if (bus.out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid: got %b want %b", bus.out_valid, q.size() > 0); end
            total++; if (bus.in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready: got %b want %b", bus.in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                total++; if (bus.out_data !== q[0]) begin bad++; $display("FAIL rnd_data: got %h want %h", bus.out_data, q[0]); end
            end
            total++; if (bus.cfg_err !== m_err) begin bad++; $display("FAIL rnd_cfg_err: got %b want %b", bus.cfg_err, m_err); end
            total++; if (bus.xfer_count !== 4'(m_xfer)) begin bad++; $display("FAIL rnd_xfer: got %0d want %0d", bus.xfer_count, m_xfer); end
        end
        bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_mode = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_invert();
        test_cfg_pass();
        test_cfg_rot();
        test_back_to_back();
        test_cfg_err();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
